// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide unit.
package muldiv_pkg;

    localparam int MD_ITER = 32;

    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_DIV   = 2'd2;
    localparam logic [1:0] MD_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } md_state_e;

endpackage

// File: rtl/muldiv_iter_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
// Divide packing: i_acc = {partial remainder[32:0], quotient/dividend[31:0]}.
module muldiv_iter_step (
    input  logic [64:0] i_acc,
    input  logic [31:0] i_opnd,
    input  logic        i_is_div,
    output logic [64:0] o_acc
);

    logic [32:0] w_sum;
    logic [32:0] w_add;
    logic [33:0] w_shift;
    logic [32:0] w_diff;
    logic        w_ge;

    assign w_sum   = {1'b0, i_acc[63:32]} + {1'b0, i_opnd};
    assign w_add   = i_acc[0] ? w_sum : {1'b0, i_acc[63:32]};

    // Remainder stays below the divisor, so the 33-bit difference never wraps.
    assign w_shift = {i_acc[64:32], i_acc[31]};
    assign w_ge    = (w_shift >= {2'b00, i_opnd});
    assign w_diff  = w_shift[32:0] - {1'b0, i_opnd};

    always_comb begin
        o_acc = {1'b0, w_add, i_acc[31:1]};
        if (i_is_div) begin
            o_acc = {(w_ge ? w_diff : w_shift[32:0]), i_acc[30:0], w_ge};
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine owning HI/LO.
// Define MULDIV_FAST_MUL_EN to compute multiplies in a single cycle and skip RUN.
module hilo_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int ITER = MD_ITER
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] hi_wdata,
    input  logic [31:0] lo_wdata,
    output logic        busy,
    output logic        done,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CW = $clog2(ITER);

    md_state_e   r_state;
    md_state_e   w_next;
    logic        r_busy;
    logic        r_done;
    logic [CW-1:0] r_cnt;
    logic [64:0] r_acc;
    logic [31:0] r_opnd;
    logic        r_is_div;
    logic        r_sign_a;
    logic        r_sign_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept;
    logic        w_is_div_in;
    logic        w_signed_in;
    logic        w_sign_a;
    logic        w_sign_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [64:0] w_step_acc;
    logic        w_sdiff;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_fix_wr;

    assign w_is_div_in = (op == MD_DIV) || (op == MD_DIVU);
    assign w_signed_in = (op == MD_MULT) || (op == MD_DIV);
    assign w_sign_a    = w_signed_in & SrcAE[31];
    assign w_sign_b    = w_signed_in & SrcBE[31];
    assign w_mag_a     = w_sign_a ? (32'd0 - SrcAE) : SrcAE;
    assign w_mag_b     = w_sign_b ? (32'd0 - SrcBE) : SrcBE;
    assign w_accept    = (r_state == S_IDLE) & start & ~flush;

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] w_fast_prod;
    assign w_fast_prod = {32'd0, w_mag_a} * {32'd0, w_mag_b};
`endif

    muldiv_iter_step u_step (
        .i_acc    (r_acc),
        .i_opnd   (r_opnd),
        .i_is_div (r_is_div),
        .o_acc    (w_step_acc)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_RUN;
`ifdef MULDIV_FAST_MUL_EN
                    if (!w_is_div_in) w_next = S_FIX;
`endif
                end
            end
            S_RUN: begin
                if (flush)                      w_next = S_IDLE;
                else if (r_cnt == CW'(ITER - 1)) w_next = S_FIX;
            end
            S_FIX:   w_next = flush ? S_IDLE : S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == S_RUN) || (w_next == S_FIX);
            r_done  <= (w_next == S_DONE);
        end
    end

    // Sign correction applied to the magnitude result in FIX.
    assign w_sdiff  = r_sign_a ^ r_sign_b;
    assign w_prod   = w_sdiff  ? (64'd0 - r_acc[63:0])  : r_acc[63:0];
    assign w_quot   = w_sdiff  ? (32'd0 - r_acc[31:0])  : r_acc[31:0];
    assign w_rem    = r_sign_a ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
    assign w_res_hi = r_is_div ? w_rem  : w_prod[63:32];
    assign w_res_lo = r_is_div ? w_quot : w_prod[31:0];
    assign w_fix_wr = (r_state == S_FIX) & ~flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_is_div <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            if (w_accept) begin
                r_is_div <= w_is_div_in;
                r_sign_a <= w_sign_a;
                r_sign_b <= w_sign_b;
                r_cnt    <= '0;
                r_opnd   <= w_is_div_in ? w_mag_b : w_mag_a;
                r_acc    <= {33'd0, (w_is_div_in ? w_mag_a : w_mag_b)};
`ifdef MULDIV_FAST_MUL_EN
                if (!w_is_div_in) r_acc <= {1'b0, w_fast_prod};
`endif
            end else if (r_state == S_RUN) begin
                r_acc <= w_step_acc;
                r_cnt <= r_cnt + CW'(1);
            end

            if (hi_we)         r_hi <= hi_wdata;
            else if (w_fix_wr) r_hi <= w_res_hi;

            if (lo_we)         r_lo <= lo_wdata;
            else if (w_fix_wr) r_lo <= w_res_lo;
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign stall = (start & ~flush & ~r_busy) | r_busy;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed self-checking bench for hilo_muldiv_unit (honours MULDIV_FAST_MUL_EN).
module tb_hilo_muldiv_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] SrcAE = '0;
    logic [31:0] SrcBE = '0;
    logic        flush = 1'b0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] hi_wdata = '0;
    logic [31:0] lo_wdata = '0;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif

    hilo_muldiv_unit dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .SrcAE    (SrcAE),
        .SrcBE    (SrcBE),
        .flush    (flush),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .hi_wdata (hi_wdata),
        .lo_wdata (lo_wdata),
        .busy     (busy),
        .done     (done),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one op, waits (bounded) for done, checks latency, busy span and HI/LO.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat;
        int busy_cnt;
        op = o; SrcAE = a; SrcBE = b; start = 1'b1;
        #1;
        check({tag, " stall@T"}, 32'(stall), 32'd1);
        lat = 0;
        busy_cnt = 0;
        do begin
            tick();
            start = 1'b0;
            lat++;
            if (busy) busy_cnt++;
        end while (!done && lat < 100);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
        check({tag, " hi"}, hi, exp_hi);
        check({tag, " lo"}, lo, exp_lo);
        tick();
        check({tag, " done one-shot"}, 32'(done), 32'd0);
    endtask

    initial begin
        // Reset state
        tick(); tick();
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst hi", hi, 32'd0);
        check("rst lo", lo, 32'd0);
        check("rst stall", 32'(stall), 32'd0);
        reset = 1'b0;
        tick();

        run_op("DIVU 100/7",   2'd3, 32'd100,      32'd7,          34,      32'd2,        32'd14);
        run_op("DIV -7/2",     2'd2, 32'hFFFFFFF9, 32'd2,          34,      32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("MULT -1*2",    2'd0, 32'hFFFFFFFF, 32'd2,          MUL_LAT, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("MULTU ~0*2",   2'd1, 32'hFFFFFFFF, 32'd2,          MUL_LAT, 32'd1,        32'hFFFFFFFE);
        run_op("DIVU 5/0",     2'd3, 32'd5,        32'd0,          34,      32'd5,        32'hFFFFFFFF);
        run_op("DIV ovf",      2'd2, 32'h80000000, 32'hFFFFFFFF,   34,      32'd0,        32'h80000000);
        run_op("MULT 7*-3",    2'd0, 32'd7,        32'hFFFFFFFD,   MUL_LAT, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("MULTU 2^16sq", 2'd1, 32'h00010000, 32'h00010000,   MUL_LAT, 32'd1,        32'd0);
        run_op("DIV 7/-2",     2'd2, 32'd7,        32'hFFFFFFFE,   34,      32'd1,        32'hFFFFFFFD);

        // Direct writes appear the cycle after the strobe
        hi_we = 1'b1; hi_wdata = 32'hCAFEF00D;
        lo_we = 1'b1; lo_wdata = 32'h12345678;
        #1;
        check("mthi before edge", hi, 32'd1);
        tick();
        hi_we = 1'b0; lo_we = 1'b0;
        check("mthi", hi, 32'hCAFEF00D);
        check("mtlo", lo, 32'h12345678);

        // Flush at T+10
        op = 2'd3; SrcAE = 32'd100; SrcBE = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush busy", 32'(busy), 32'd0);
        check("flush done", 32'(done), 32'd0);
        check("flush hi", hi, 32'hCAFEF00D);
        check("flush lo", lo, 32'h12345678);
        run_op("post-flush DIVU 1000/3", 2'd3, 32'd1000, 32'd3, 34, 32'd1, 32'd333);

        // Direct HI write colliding with the FIX write
        op = 2'd3; SrcAE = 32'd100; SrcBE = 32'd7; start = 1'b1;
        for (int i = 0; i < 33; i++) begin
            tick();
            start = 1'b0;
        end
        check("coll busy@FIX", 32'(busy), 32'd1);
        hi_we = 1'b1; hi_wdata = 32'hDEADBEEF;
        tick();
        hi_we = 1'b0;
        check("coll done", 32'(done), 32'd1);
        check("coll hi", hi, 32'hDEADBEEF);
        check("coll lo", lo, 32'd14);
        tick();

        // Asynchronous reset mid-operation
        op = 2'd2; SrcAE = 32'd9; SrcBE = 32'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("pre-rst busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async rst busy", 32'(busy), 32'd0);
        check("async rst done", 32'(done), 32'd0);
        check("async rst hi", hi, 32'd0);
        check("async rst lo", lo, 32'd0);
        check("async rst stall", 32'(stall), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        run_op("after rst DIVU 9/2", 2'd3, 32'd9, 32'd2, 34, 32'd1, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
